// File: rtl/game_state_ctrl.sv
// Game-flow sequencer for the Pac-Man VGA design: INIT/PLAY/DEATH/CLEAR/OVER with lives, level and per-ghost collision.
// Optional macro EXTRA_LIFE_EN: award one (saturating) life on every level clear.
module game_state_ctrl #(
    parameter int N_GHOSTS     = 2,
    parameter int X_W          = 6,
    parameter int Y_W          = 5,
    parameter int PILL_W       = 9,
    parameter int LIVES_W      = 3,
    parameter int START_LIVES  = 3,
    parameter int LEVEL_W      = 4,
    parameter int RESUME_DELAY = 250000000
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      start,
    input  logic [X_W-1:0]            pac_x,
    input  logic [Y_W-1:0]            pac_y,
    input  logic [N_GHOSTS*X_W-1:0]   ghost_x,
    input  logic [N_GHOSTS*Y_W-1:0]   ghost_y,
    input  logic [PILL_W-1:0]         pill_count,
    output logic [2:0]                state,
    output logic                      sprite_reset,
    output logic                      map_wr_reset,
    output logic                      ghost_enable,
    output logic                      counter_reset,
    output logic [N_GHOSTS-1:0]       collide_vec,
    output logic [LIVES_W-1:0]        lives,
    output logic [LEVEL_W-1:0]        level,
    output logic                      life_lost,
    output logic                      level_clear
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_PLAY  = 3'd1,
        S_DEATH = 3'd2,
        S_CLEAR = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int TIMER_W = $clog2(RESUME_DELAY);
    localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(RESUME_DELAY - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_MAX   = {LIVES_W{1'b1}};
    localparam logic [LEVEL_W-1:0] LEVEL_MAX   = {LEVEL_W{1'b1}};

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [LIVES_W-1:0]  lives_d;
    logic [LEVEL_W-1:0]  level_d;
    logic                armed_q, armed_d;
    logic                life_lost_d, level_clear_d;
    logic                hit;

    assign hit = |collide_vec;

    // Per-ghost compare is registered; the armed flag hides the stale value
    // left over from the cycles before PLAY was (re)entered.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            collide_vec <= '0;
        end else begin
            for (int i = 0; i < N_GHOSTS; i++) begin
                collide_vec[i] <= (ghost_x[i*X_W +: X_W] == pac_x) &&
                                  (ghost_y[i*Y_W +: Y_W] == pac_y);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_INIT;
            timer_q     <= '0;
            lives       <= LIVES_INIT;
            level       <= '0;
            armed_q     <= 1'b0;
            life_lost   <= 1'b0;
            level_clear <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lives       <= lives_d;
            level       <= level_d;
            armed_q     <= armed_d;
            life_lost   <= life_lost_d;
            level_clear <= level_clear_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        lives_d       = lives;
        level_d       = level;
        life_lost_d   = 1'b0;
        level_clear_d = 1'b0;
        case (state_q)
            S_INIT: begin
                lives_d = LIVES_INIT;
                level_d = '0;
                if (start) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (armed_q) begin
                    if (hit) begin
                        life_lost_d = 1'b1;
                        if (lives > LIVES_W'(1)) begin
                            lives_d = lives - LIVES_W'(1);
                            timer_d = TIMER_LOAD;
                            state_d = S_DEATH;
                        end else begin
                            lives_d = '0;
                            state_d = S_OVER;
                        end
                    end else if (pill_count == '0) begin
                        level_d       = (level == LEVEL_MAX) ? level : level + LEVEL_W'(1);
                        level_clear_d = 1'b1;
                        timer_d       = TIMER_LOAD;
                        state_d       = S_CLEAR;
`ifdef EXTRA_LIFE_EN
                        lives_d       = (lives == LIVES_MAX) ? lives : lives + LIVES_W'(1);
`endif
                    end
                end
            end
            S_DEATH, S_CLEAR: begin
                if (timer_q == '0) state_d = S_PLAY;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: state_d = S_INIT;
        endcase
        // Armed only from the second consecutive PLAY cycle onward.
        armed_d = (state_q == S_PLAY) && (state_d == S_PLAY);
    end

`ifndef EXTRA_LIFE_EN
    logic unused_max;
    assign unused_max = &LIVES_MAX;
`endif

    assign state         = state_q;
    assign sprite_reset  = (state_q == S_INIT) || (state_q == S_DEATH) || (state_q == S_CLEAR);
    assign map_wr_reset  = (state_q == S_INIT) || (state_q == S_CLEAR) || (state_q == S_OVER);
    assign ghost_enable  = (state_q == S_PLAY);
    assign counter_reset = (state_q == S_INIT);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with RESUME_DELAY=4; expected output words queued per step.
module tb_game_state_ctrl;

    localparam int OBS_W = 18;

    logic        CLOCK_50 = 1'b0;
    logic        reset, start;
    logic [5:0]  pac_x;
    logic [4:0]  pac_y;
    logic [11:0] ghost_x;
    logic [9:0]  ghost_y;
    logic [8:0]  pill_count;
    logic [2:0]  state;
    logic        sprite_reset, map_wr_reset, ghost_enable, counter_reset;
    logic [1:0]  collide_vec;
    logic [2:0]  lives;
    logic [3:0]  level;
    logic        life_lost, level_clear;

    int tests_run = 0;
    int tests_failed = 0;
    logic [OBS_W-1:0] exp_q[$];
    int exp_lives;
    int exp_level;

    game_state_ctrl #(
        .N_GHOSTS(2), .X_W(6), .Y_W(5), .PILL_W(9), .LIVES_W(3),
        .START_LIVES(3), .LEVEL_W(4), .RESUME_DELAY(4)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .pill_count(pill_count), .state(state), .sprite_reset(sprite_reset),
        .map_wr_reset(map_wr_reset), .ghost_enable(ghost_enable),
        .counter_reset(counter_reset), .collide_vec(collide_vec), .lives(lives),
        .level(level), .life_lost(life_lost), .level_clear(level_clear)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [OBS_W-1:0] mk(input int st, input int lv, input int lev,
                                            input logic ll, input logic lc, input logic [1:0] cv);
        logic sr, mr, ge, cr;
        sr = (st == 0) || (st == 2) || (st == 3);
        mr = (st == 0) || (st == 3) || (st == 4);
        ge = (st == 1);
        cr = (st == 0);
        return {3'(st), 3'(lv), 4'(lev), ll, lc, sr, mr, ge, cr, cv};
    endfunction

    function automatic logic [OBS_W-1:0] obs();
        return {state, lives, level, life_lost, level_clear, sprite_reset,
                map_wr_reset, ghost_enable, counter_reset, collide_vec};
    endfunction

    task automatic set_ghost(input int g, input int x, input int y);
        ghost_x[g*6 +: 6] = 6'(x);
        ghost_y[g*5 +: 5] = 5'(y);
    endtask

    // Queue the expected word, advance one clock, compare after the edge settles.
    task automatic step_expect(input string tag, input logic [OBS_W-1:0] exp);
        logic [OBS_W-1:0] e, got;
        exp_q.push_back(exp);
        @(posedge CLOCK_50);
        #1;
        e   = exp_q.pop_front();
        got = obs();
        tests_run++;
        assert (got === e) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, got, e);
        end
    endtask

    task automatic clear_lives();
`ifdef EXTRA_LIFE_EN
        if (exp_lives < 7) exp_lives++;
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pac_x = 6'd5; pac_y = 5'd5;
        ghost_x = '0; ghost_y = '0;
        set_ghost(0, 10, 10); set_ghost(1, 20, 20);
        pill_count = 9'd100;
        exp_lives = 3; exp_level = 0;

        step_expect("reset0", mk(0, 3, 0, 0, 0, 2'b00));
        step_expect("reset1", mk(0, 3, 0, 0, 0, 2'b00));
        reset = 1'b0;
        step_expect("init_idle", mk(0, 3, 0, 0, 0, 2'b00));
        start = 1'b1;
        step_expect("start_play", mk(1, 3, 0, 0, 0, 2'b00));
        start = 1'b0;
        step_expect("play_arm", mk(1, 3, 0, 0, 0, 2'b00));

        // First hit by ghost 1, which stays on Pac-Man through DEATH.
        set_ghost(1, 5, 5);
        step_expect("cv_ghost1", mk(1, 3, 0, 0, 0, 2'b10));
        step_expect("death1_entry", mk(2, 2, 0, 1, 0, 2'b10));
        for (int i = 0; i < 3; i++) step_expect("death1_dwell", mk(2, 2, 0, 0, 0, 2'b10));
        step_expect("death1_resume", mk(1, 2, 0, 0, 0, 2'b10));
        set_ghost(1, 20, 20);
        step_expect("armed_mask", mk(1, 2, 0, 0, 0, 2'b00));
        step_expect("play_after_mask", mk(1, 2, 0, 0, 0, 2'b00));

        // Second hit by ghost 0.
        set_ghost(0, 5, 5);
        step_expect("cv_ghost0", mk(1, 2, 0, 0, 0, 2'b01));
        step_expect("death2_entry", mk(2, 1, 0, 1, 0, 2'b01));
        set_ghost(0, 10, 10);
        for (int i = 0; i < 3; i++) step_expect("death2_dwell", mk(2, 1, 0, 0, 0, 2'b00));
        step_expect("death2_resume", mk(1, 1, 0, 0, 0, 2'b00));
        step_expect("death2_arm", mk(1, 1, 0, 0, 0, 2'b00));

        // Third hit ends the game.
        set_ghost(1, 5, 5);
        step_expect("cv_hit3", mk(1, 1, 0, 0, 0, 2'b10));
        step_expect("over_entry", mk(4, 0, 0, 1, 0, 2'b10));
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            step_expect("over_hold", mk(4, 0, 0, 0, 0, 2'b10));
        end
        reset = 1'b1; start = 1'b0;
        step_expect("reset_from_over", mk(0, 3, 0, 0, 0, 2'b00));
        reset = 1'b0;
        set_ghost(1, 20, 20);
        start = 1'b1;
        step_expect("restart_play", mk(1, 3, 0, 0, 0, 2'b00));
        start = 1'b0;
        step_expect("restart_arm", mk(1, 3, 0, 0, 0, 2'b00));

        // Level clear.
        pill_count = 9'd0;
        clear_lives(); exp_level = 1;
        step_expect("clear_entry", mk(3, exp_lives, 1, 0, 1, 2'b00));
        pill_count = 9'd100;
        for (int i = 0; i < 3; i++) step_expect("clear_dwell", mk(3, exp_lives, 1, 0, 0, 2'b00));
        step_expect("clear_resume", mk(1, exp_lives, 1, 0, 0, 2'b00));
        step_expect("clear_arm", mk(1, exp_lives, 1, 0, 0, 2'b00));

        // Hit and empty map in the same cycle: death wins.
        set_ghost(0, 5, 5);
        step_expect("both_cv", mk(1, exp_lives, 1, 0, 0, 2'b01));
        pill_count = 9'd0;
        exp_lives--;
        step_expect("both_death", mk(2, exp_lives, 1, 1, 0, 2'b01));
        pill_count = 9'd100;
        set_ghost(0, 10, 10);
        for (int i = 0; i < 3; i++) step_expect("both_dwell", mk(2, exp_lives, 1, 0, 0, 2'b00));
        step_expect("both_resume", mk(1, exp_lives, 1, 0, 0, 2'b00));
        step_expect("both_arm", mk(1, exp_lives, 1, 0, 0, 2'b00));

        // Drive the level counter to saturation and one clear beyond.
        for (int n = 0; n < 15; n++) begin
            pill_count = 9'd0;
            clear_lives();
            if (exp_level < 15) exp_level++;
            step_expect("sat_clear_entry", mk(3, exp_lives, exp_level, 0, 1, 2'b00));
            pill_count = 9'd100;
            for (int i = 0; i < 3; i++) step_expect("sat_clear_dwell", mk(3, exp_lives, exp_level, 0, 0, 2'b00));
            step_expect("sat_resume", mk(1, exp_lives, exp_level, 0, 0, 2'b00));
            step_expect("sat_arm", mk(1, exp_lives, exp_level, 0, 0, 2'b00));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Parametrised top-level game-flow controller for the Pac-Man VGA design. It generalises the inline init/game/resume/over sequencer to N ghosts, adds a level-clear state with a level counter, and a registered, per-ghost collision vector. It drives sprite/map/pill-counter resets and ghost enable, and keeps lives and level.

Parameters:
N_GHOSTS, 2, number of ghosts compared against Pac-Man (1..8)
X_W, 6, grid x coordinate width (0~39)
Y_W, 5, grid y coordinate width (0~29)
PILL_W, 9, width of remaining-pill count
LIVES_W, 3, width of lives register
START_LIVES, 3, lives loaded in INIT (1..2**LIVES_W-1)
LEVEL_W, 4, width of level counter
RESUME_DELAY, 250000000, cycles spent in DEATH and CLEAR (5 s at 50 MHz); >=2

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high; returns block to INIT
start  in  1  level-sensitive start request (SW[9])
pac_x  in  X_W  Pac-Man next grid x
pac_y  in  Y_W  Pac-Man next grid y
ghost_x  in  N_GHOSTS*X_W  packed ghost next x, ghost i at [i*X_W +: X_W]
ghost_y  in  N_GHOSTS*Y_W  packed ghost next y, same packing
pill_count  in  PILL_W  pills remaining on map
state  out  3  INIT=0, PLAY=1, DEATH=2, CLEAR=3, OVER=4
sprite_reset  out  1  holds sprite/ghost location logic in reset
map_wr_reset  out  1  holds map RAM writer in reset / reload
ghost_enable  out  1  enables ghost AI
counter_reset  out  1  resets pill counter display
collide_vec  out  N_GHOSTS  registered per-ghost position match
lives  out  LIVES_W  remaining lives
level  out  LEVEL_W  levels cleared, saturating
life_lost  out  1  one-cycle pulse on each life decrement
level_clear  out  1  one-cycle pulse on entry to CLEAR

Behaviour:
- Reset (sync): state=INIT, lives=START_LIVES, level=0, collide_vec=0, timer=0, armed=0, pulses=0. Applies mid-DEATH/CLEAR/OVER identically.
- collide_vec[i] <= (ghost_x_i==pac_x)&(ghost_y_i==pac_y) every cycle; 1-cycle latency. hit = |collide_vec.
- armed: cleared on any transition into PLAY, set after first PLAY cycle; hit/pill checks act only when state==PLAY & armed (masks stale compare).
- INIT: start=1 -> PLAY; lives=START_LIVES, level=0 held.
- PLAY (armed): priority hit over clear.
  - hit & lives>1: lives-1, life_lost=1, timer=RESUME_DELAY-1, -> DEATH.
  - hit & lives==1: lives=0, life_lost=1, -> OVER.
  - !hit & pill_count==0: level+1 (saturate at all-ones), level_clear=1, timer=RESUME_DELAY-1, -> CLEAR.
  - else stay.
- DEATH/CLEAR: timer decrements each cycle; timer==0 -> PLAY. Dwell exactly RESUME_DELAY cycles. start ignored.
- OVER: terminal until reset; start ignored.
- Moore outputs: sprite_reset=1 in INIT, DEATH, CLEAR; map_wr_reset=1 in INIT, CLEAR, OVER; ghost_enable=1 only PLAY; counter_reset=1 only INIT.
- Pulses registered, high exactly the first cycle of the new state.
- timer width $clog2(RESUME_DELAY); never wraps (reloaded before use).

Optional Feature:
EXTRA_LIFE_EN: defined -> on each PLAY->CLEAR transition lives increments by 1, saturating at 2**LIVES_W-1. Undefined -> lives unchanged on level clear.

Test Plan:
- RESUME_DELAY=4; reset, start=1 -> state INIT->PLAY next cycle, lives=3, ghost_enable=1, sprite_reset=0.
- PLAY, set ghost1 pos = pac pos -> collide_vec=2'b10 one cycle later, next cycle state=DEATH, lives=2, life_lost pulse; exactly 4 cycles later state=PLAY.
- Three successive hits from lives=3 -> third hit goes PLAY->OVER, lives=0; start toggling leaves OVER; reset -> INIT, lives=3.
- pill_count=0, no hit -> CLEAR, level=1, level_clear pulse, map_wr_reset=1 for 4 cycles, then PLAY; level=15 + clear -> stays 15.
- Simultaneous hit & pill_count=0 -> DEATH (not CLEAR), level unchanged; collision on first PLAY cycle after DEATH ignored (armed=0).
- EXTRA_LIFE_EN defined, lives=2, clear -> lives=3; lives=7 clear -> lives=7; undefined -> lives=2 unchanged.
